stream_rr_arbiter: RTL

//  Round-robin arbiter that shares one 8-bit valid/ready stream sink between N_REQ requesters.

---
 rtl/stream_rr_arbiter_if.sv | 58 +++++
 rtl/stream_rr_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// stream_rr_arbiter_if
//   Bundles the signals around stream_rr_arbiter: the N_REQ requester streams
//   on one side, the shared registered output stream on the other, plus the
//   grant/busy status outputs.
//
//   Signals
//     req_valid        N_REQ              per-requester beat valid
//     req_data         N_REQ*DATA_WIDTH   requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready        N_REQ              per-requester accept, at most one bit set
//     stream_out_valid 1                  registered output beat valid
//     stream_out_data  DATA_WIDTH         registered output beat data
//     stream_out_ready 1                  downstream accept
//     grant_id         GrantWidth         current/last granted requester
//     busy             1                  high while a burst is granted
//
//   Modports
//     master  arbiter side (drives ready, output stream and status)
//     slave   environment side (drives requests and downstream ready)
// ----------------------------------------------------------------------------
interface stream_rr_arbiter_if #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    // A single requester still needs a 1-bit grant field.
    localparam int unsigned GrantWidth = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic                        stream_out_valid;
    logic [DATA_WIDTH-1:0]       stream_out_data;
    logic                        stream_out_ready;
    logic [GrantWidth-1:0]       grant_id;
    logic                        busy;

    modport master (
        input  req_valid,
        input  req_data,
        input  stream_out_ready,
        output req_ready,
        output stream_out_valid,
        output stream_out_data,
        output grant_id,
        output busy
    );

    modport slave (
        output req_valid,
        output req_data,
        output stream_out_ready,
        input  req_ready,
        input  stream_out_valid,
        input  stream_out_data,
        input  grant_id,
        input  busy
    );
endinterface

// File: rtl/stream_rr_arbiter.sv
// ----------------------------------------------------------------------------
// stream_rr_arbiter
//   Round-robin arbiter sharing one valid/ready stream sink between N_REQ
//   requesters. One requester is granted at a time for a burst of at most
//   MAX_BURST beats; beats pass through a one-entry registered output stage
//   that sustains one beat per clock under full-rate backpressure.
//
//   Ports
//     clk     in  clock, all state on the rising edge
//     reset   in  asynchronous active-high reset
//     bus_io  master modport of stream_rr_arbiter_if (requests, output
//             stream, grant_id, busy)
//
//   Operation
//     Idle : no beat accepted; the first valid requester found searching
//            from the priority pointer is registered as the grant.
//     Burst: only the granted requester sees ready, and only while the
//            output slot is empty or being drained this cycle. The burst
//            ends after MAX_BURST beats, or as soon as the requester is idle
//            while a slot is free; the pointer then moves past the grant.
// ----------------------------------------------------------------------------
module stream_rr_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input logic                 clk,
    input logic                 reset,
    stream_rr_arbiter_if.master bus_io
);
    localparam int unsigned GrantWidth = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntWidth   = $clog2(MAX_BURST + 1);

    typedef logic [GrantWidth-1:0] idx_t;
    typedef logic [CntWidth-1:0]   cnt_t;

    localparam idx_t LastIdx  = idx_t'(N_REQ - 1);
    localparam cnt_t LastBeat = cnt_t'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } state_e;

    state_e                state_q, state_d;
    idx_t                  ptr_q, ptr_d;
    idx_t                  grant_q, grant_d;
    cnt_t                  beat_cnt_q, beat_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic [N_REQ-1:0]      ready_vec;
    logic                  slot_free;
    logic                  xfer;
    logic                  rel;
    logic                  pick_found;
    idx_t                  pick_idx;
    idx_t                  grant_next;

    // Per-requester view of the flattened data bus.
    logic [DATA_WIDTH-1:0] req_data_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_data_arr[g] = bus_io.req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // ------------------------------------------------------------------------
    // Round-robin pick: first valid requester at ptr, ptr+1, ... mod N_REQ.
    // The candidate index wraps by subtraction so non-power-of-2 N_REQ works.
    // ------------------------------------------------------------------------
    always_comb begin
        int unsigned cand;
        idx_t        cand_idx;
        cand       = 0;
        cand_idx   = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = idx_t'(cand);
            if (!pick_found && bus_io.req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Requester after the current grant, wrapping N_REQ-1 -> 0.
    assign grant_next = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;

    // The output register can take a beat if empty or draining this cycle.
    assign slot_free = !out_valid_q || bus_io.stream_out_ready;

    // ------------------------------------------------------------------------
    // Next-state logic: arbitration FSM and output stage.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ready_vec   = '0;
        xfer        = 1'b0;
        rel         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = StBurst;
                end
            end
            StBurst: begin
                ready_vec[grant_q] = slot_free;
                xfer = slot_free && bus_io.req_valid[grant_q];
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // Release only when a slot is free: either the last allowed
                // beat is moving now, or the requester has nothing to send.
                // A stalled output never ends the burst.
                rel = slot_free
                    && (!bus_io.req_valid[grant_q] || (beat_cnt_q == LastBeat));
                if (rel) begin
                    state_d = StIdle;
                    ptr_d   = grant_next;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Output stage: a push wins over a pop, so pop+push keeps valid high.
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data_arr[grant_q];
        end else if (bus_io.stream_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State registers. Reset drops any held output beat.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus_io.req_ready        = ready_vec;
    assign bus_io.stream_out_valid = out_valid_q;
    assign bus_io.stream_out_data  = out_data_q;
    assign bus_io.grant_id         = grant_q;
    assign bus_io.busy             = (state_q == StBurst);
endmodule
